// File: rtl/freq_sweep_ctrl_if.sv
// Control/config and tuning-word bundle between a sweep client and freq_sweep_ctrl.
interface freq_sweep_ctrl_if #(
    parameter int PHASE_W = 32,
    parameter int DWELL_W = 16
) ();
    logic               start;
    logic               abort;
    logic [PHASE_W-1:0] cfg_start_step;
    logic [PHASE_W-1:0] cfg_stop_step;
    logic [PHASE_W-1:0] cfg_inc;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic [PHASE_W-1:0] phase_step;
    logic               busy;
    logic               step_strobe;
    logic               sweep_done;

    modport master (
        output start, abort, cfg_start_step, cfg_stop_step, cfg_inc, cfg_dwell, cfg_mode,
        input  phase_step, busy, step_strobe, sweep_done
    );

    modport slave (
        input  start, abort, cfg_start_step, cfg_stop_step, cfg_inc, cfg_dwell, cfg_mode,
        output phase_step, busy, step_strobe, sweep_done
    );
endinterface

// File: rtl/freq_sweep_ctrl.sv
// Linear frequency-sweep generator producing the DDS tuning word, with dwell per step,
// single / repeat / up-down modes and abort.
module freq_sweep_ctrl #(
    parameter int PHASE_W = 32,
    parameter int DWELL_W = 16
) (
    input logic              clk,
    input logic              rst,
    freq_sweep_ctrl_if.slave bus_if
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_UPDOWN = 2'b10;

    state_e             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] start_q;
    logic [PHASE_W-1:0] stop_q;
    logic [PHASE_W-1:0] inc_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [1:0]         mode_q;
    logic               busy_q;
    logic               strobe_q;
    logic               done_q;

    logic [PHASE_W:0]   up_sum_d;
    logic [PHASE_W-1:0] up_next_d;
    logic [PHASE_W-1:0] down_diff_d;
    logic [PHASE_W-1:0] down_next_d;
    logic               at_stop_d;
    logic               at_start_d;
    logic               ramp_ok_d;
    logic               single_d;

    // Next up/down tuning words, clamped to the latched endpoints; inc=0 jumps straight there
    always_comb begin
        up_sum_d    = {1'b0, phase_q} + {1'b0, inc_q};
        down_diff_d = phase_q - start_q;
        if ((inc_q == '0) || (up_sum_d >= {1'b0, stop_q})) begin
            up_next_d = stop_q;
        end else begin
            up_next_d = up_sum_d[PHASE_W-1:0];
        end
        if ((inc_q == '0) || (down_diff_d <= inc_q)) begin
            down_next_d = start_q;
        end else begin
            down_next_d = phase_q - inc_q;
        end
        at_stop_d  = (phase_q >= stop_q);
        at_start_d = (phase_q <= start_q);
        ramp_ok_d  = (start_q < stop_q);
        single_d   = (mode_q != MODE_REPEAT) && (mode_q != MODE_UPDOWN);
    end

    // Sweep state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            start_q  <= '0;
            stop_q   <= '0;
            inc_q    <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= 2'b00;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.start && !bus_if.abort) begin
                        start_q  <= bus_if.cfg_start_step;
                        stop_q   <= bus_if.cfg_stop_step;
                        inc_q    <= bus_if.cfg_inc;
                        dwell_q  <= bus_if.cfg_dwell;
                        mode_q   <= bus_if.cfg_mode;
                        phase_q  <= bus_if.cfg_start_step;
                        cnt_q    <= bus_if.cfg_dwell;
                        busy_q   <= 1'b1;
                        strobe_q <= 1'b1;
                        state_q  <= ST_UP;
                    end
                end
                ST_UP, ST_DOWN: begin
                    if (bus_if.abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (state_q == ST_UP) begin
                        if (!at_stop_d) begin
                            phase_q  <= up_next_d;
                            cnt_q    <= dwell_q;
                            strobe_q <= 1'b1;
                        end else if (single_d) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (!ramp_ok_d) begin
                            // start >= stop: hold the start value forever, no strobes
                            phase_q <= phase_q;
                        end else if (mode_q == MODE_REPEAT) begin
                            phase_q  <= start_q;
                            cnt_q    <= dwell_q;
                            strobe_q <= 1'b1;
                        end else begin
                            state_q  <= ST_DOWN;
                            phase_q  <= down_next_d;
                            cnt_q    <= dwell_q;
                            strobe_q <= 1'b1;
                        end
                    end else begin
                        if (at_start_d) begin
                            state_q <= ST_UP;
                            phase_q <= up_next_d;
                        end else begin
                            phase_q <= down_next_d;
                        end
                        cnt_q    <= dwell_q;
                        strobe_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_if.phase_step  = phase_q;
    assign bus_if.busy        = busy_q;
    assign bus_if.step_strobe = strobe_q;
    assign bus_if.sweep_done  = done_q;
endmodule
